// File: rtl/flag_fifo_buf.sv
// Multi-entry flag buffer: queues up to 2^A words and presents the oldest on dout while flag is high.
// Optional build macro FLAG_FIFO_OVERWRITE_EN: a push into a full queue overwrites the oldest entry.
module flag_fifo_buf #(
    parameter int W = 8,
    parameter int A = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         set_flag,
    input  logic         clr_flag,
    input  logic         clr_ovr,
    input  logic [W-1:0] din,
    output logic         flag,
    output logic         full,
    output logic [A:0]   count,
    output logic         overrun,
    output logic [W-1:0] dout
);

    localparam int         DEPTH     = 1 << A;
    localparam logic [A:0] DEPTH_CNT = (A+1)'(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];
    logic [A-1:0] wr_ptr_q, wr_ptr_d;
    logic [A-1:0] rd_ptr_q, rd_ptr_d;
    logic [A:0]   count_q, count_d;
    logic         overrun_q, overrun_d;

    logic full_s;
    logic pop_ok_s;
    logic push_ok_s;
    logic drop_s;
    logic rd_adv_s;
    logic cnt_inc_s;
    logic cnt_dec_s;

    // Decode accepted push/pop/drop events from registered state and requests.
    always_comb begin
        full_s   = (count_q == DEPTH_CNT);
        pop_ok_s = clr_flag && (count_q != {(A+1){1'b0}});
`ifdef FLAG_FIFO_OVERWRITE_EN
        // Full without pop: the push replaces the oldest word, so both pointers move.
        push_ok_s = set_flag;
        drop_s    = set_flag && full_s && !pop_ok_s;
        rd_adv_s  = pop_ok_s || drop_s;
        cnt_inc_s = push_ok_s && !pop_ok_s && !drop_s;
`else
        push_ok_s = set_flag && (!full_s || pop_ok_s);
        drop_s    = set_flag && full_s && !pop_ok_s;
        rd_adv_s  = pop_ok_s;
        cnt_inc_s = push_ok_s && !pop_ok_s;
`endif
        cnt_dec_s = pop_ok_s && !push_ok_s;
    end

    // Next-state computation for storage, pointers, occupancy and sticky overrun.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        overrun_d = overrun_q;

        if (push_ok_s) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (rd_adv_s) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        if (cnt_inc_s) begin
            count_d = count_q + 1'b1;
        end else if (cnt_dec_s) begin
            count_d = count_q - 1'b1;
        end else begin
            count_d = count_q;
        end

        // A drop in the same cycle as clr_ovr keeps the flag set.
        if (drop_s) begin
            overrun_d = 1'b1;
        end else if (clr_ovr) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {W{1'b0}};
            end
            wr_ptr_q  <= {A{1'b0}};
            rd_ptr_q  <= {A{1'b0}};
            count_q   <= {(A+1){1'b0}};
            overrun_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    assign flag    = (count_q != {(A+1){1'b0}});
    assign full    = (count_q == DEPTH_CNT);
    assign count   = count_q;
    assign overrun = overrun_q;
    assign dout    = mem_q[rd_ptr_q];

endmodule

// File: tb/tb_flag_fifo_buf.sv
// Directed self-checking bench for flag_fifo_buf (W=8, A=2), both default and overwrite builds.
module tb_flag_fifo_buf;

    logic       clk;
    logic       reset;
    logic       set_flag;
    logic       clr_flag;
    logic       clr_ovr;
    logic [7:0] din;
    logic       flag;
    logic       full;
    logic [2:0] count;
    logic       overrun;
    logic [7:0] dout;

    int checks = 0;
    int errors = 0;

    flag_fifo_buf #(.W(8), .A(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .set_flag (set_flag),
        .clr_flag (clr_flag),
        .clr_ovr  (clr_ovr),
        .din      (din),
        .flag     (flag),
        .full     (full),
        .count    (count),
        .overrun  (overrun),
        .dout     (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock with the given requests; returns 1 time unit after the edge with inputs idle.
    task automatic cyc(input logic s, input logic c, input logic o, input logic [7:0] d);
        set_flag = s;
        clr_flag = c;
        clr_ovr  = o;
        din      = d;
        @(posedge clk);
        #1;
        set_flag = 1'b0;
        clr_flag = 1'b0;
        clr_ovr  = 1'b0;
        din      = 8'h00;
    endtask

    initial begin
        reset    = 1'b1;
        set_flag = 1'b0;
        clr_flag = 1'b0;
        clr_ovr  = 1'b0;
        din      = 8'h00;
        #12;
        check("rst_flag", 32'(flag), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_ovr", 32'(overrun), 32'd0);
        check("rst_dout", 32'(dout), 32'h00);
        reset = 1'b0;

        // Asynchronous reset with three words held
        cyc(1'b1, 1'b0, 1'b0, 8'h01);
        cyc(1'b1, 1'b0, 1'b0, 8'h02);
        cyc(1'b1, 1'b0, 1'b0, 8'h03);
        check("pre_rst_count", 32'(count), 32'd3);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_count", 32'(count), 32'd0);
        check("async_rst_flag", 32'(flag), 32'd0);
        check("async_rst_dout", 32'(dout), 32'h00);
        #2;
        reset = 1'b0;

        // In-order push/pop
        cyc(1'b1, 1'b0, 1'b0, 8'h11);
        check("p1_count", 32'(count), 32'd1);
        check("p1_flag", 32'(flag), 32'd1);
        check("p1_dout", 32'(dout), 32'h11);
        cyc(1'b1, 1'b0, 1'b0, 8'h22);
        check("p2_count", 32'(count), 32'd2);
        check("p2_dout", 32'(dout), 32'h11);
        cyc(1'b1, 1'b0, 1'b0, 8'h33);
        check("p3_count", 32'(count), 32'd3);
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        check("q1_count", 32'(count), 32'd2);
        check("q1_dout", 32'(dout), 32'h22);
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        check("q2_count", 32'(count), 32'd1);
        check("q2_dout", 32'(dout), 32'h33);
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        check("q3_count", 32'(count), 32'd0);
        check("q3_flag", 32'(flag), 32'd0);

        // Fill, then push into a full queue
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0, 8'hA0 + 8'(i));
        check("fill_full", 32'(full), 32'd1);
        check("fill_count", 32'(count), 32'd4);
        check("fill_ovr", 32'(overrun), 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 8'hA4);
        check("ovf_ovr", 32'(overrun), 32'd1);
        check("ovf_count", 32'(count), 32'd4);
        check("ovf_full", 32'(full), 32'd1);
        for (int i = 0; i < 4; i++) begin
`ifdef FLAG_FIFO_OVERWRITE_EN
            check("ovf_pop_dout", 32'(dout), 32'hA1 + 32'(i));
`else
            check("ovf_pop_dout", 32'(dout), 32'hA0 + 32'(i));
`endif
            cyc(1'b0, 1'b1, 1'b0, 8'h00);
        end
        check("ovf_drain_count", 32'(count), 32'd0);
        check("ovr_sticky", 32'(overrun), 32'd1);
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        check("ovr_cleared", 32'(overrun), 32'd0);

        // Full queue with simultaneous push and pop
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0, 8'hB0 + 8'(i));
        cyc(1'b1, 1'b1, 1'b0, 8'h5C);
        check("fsp_count", 32'(count), 32'd4);
        check("fsp_ovr", 32'(overrun), 32'd0);
        check("fsp_dout", 32'(dout), 32'hB1);
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        check("fsp_d2", 32'(dout), 32'hB2);
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        check("fsp_d3", 32'(dout), 32'hB3);
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        check("fsp_last", 32'(dout), 32'h5C);
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        check("fsp_drain", 32'(count), 32'd0);

        // Empty queue with simultaneous push and pop, then pop on empty
        cyc(1'b1, 1'b1, 1'b0, 8'h77);
        check("esp_count", 32'(count), 32'd1);
        check("esp_dout", 32'(dout), 32'h77);
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        check("esp_pop_count", 32'(count), 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        check("empty_pop_count", 32'(count), 32'd0);
        check("empty_pop_flag", 32'(flag), 32'd0);
        check("empty_pop_ovr", 32'(overrun), 32'd0);

        // clr_ovr in the same cycle as a dropped push: set wins
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0, 8'hC0 + 8'(i));
        cyc(1'b1, 1'b0, 1'b0, 8'hCC);
        check("drop_ovr", 32'(overrun), 32'd1);
        cyc(1'b1, 1'b0, 1'b1, 8'hCD);
        check("set_wins_ovr", 32'(overrun), 32'd1);
        check("set_wins_count", 32'(count), 32'd4);
`ifdef FLAG_FIFO_OVERWRITE_EN
        check("set_wins_dout", 32'(dout), 32'hC2);
`else
        check("set_wins_dout", 32'(dout), 32'hC0);
`endif
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 8'h00);
        check("c_drain_count", 32'(count), 32'd0);
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        check("c_ovr_clear", 32'(overrun), 32'd0);

        // Pointer wrap with push/pop pairs at occupancy 1
        cyc(1'b1, 1'b0, 1'b0, 8'hD0);
        for (int i = 1; i <= 6; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 8'hD0 + 8'(i));
            check("wrap_dout", 32'(dout), 32'hD0 + 32'(i));
            check("wrap_count", 32'(count), 32'd1);
        end
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        check("wrap_end_count", 32'(count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
